// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
//   Conditions raw board buttons/switches: synchronises each pin into Clk,
//   filters contact bounce per bit and presents a clean active-high level
//   (1 = pressed/on). An optional one-cycle Change pulse marks each accepted
//   transition.
//
//   Optional feature macro: KEY_DEBOUNCE_CHANGE_EN
//     defined     -> Change is a registered one-cycle pulse per accepted edge
//     not defined -> Change is tied to 0 and its registers are not built
//
// Ports
//   Clk     in   1      system clock
//   Reset   in   1      asynchronous, active-high reset
//   Raw     in   WIDTH  raw asynchronous pin levels
//   Stable  out  WIDTH  debounced level, registered
//   Change  out  WIDTH  one-cycle pulse per bit on accepted transition
//   Any     out  1      OR-reduction of Stable, registered
// ---------------------------------------------------------------------------
module key_debounce #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned CNT_W      = 20,
    parameter int unsigned CNT_MAX    = 500000,
    parameter int unsigned ACTIVE_LOW = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Raw,
    output logic [WIDTH-1:0] Stable,
    output logic [WIDTH-1:0] Change,
    output logic             Any
);

    localparam logic [WIDTH-1:0] INV_MASK = (ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [CNT_W-1:0] cnt      [WIDTH];
    logic [CNT_W-1:0] cnt_next [WIDTH];
    logic [WIDTH-1:0] accept;
    logic [WIDTH-1:0] stable_next;

    // Two-flop synchroniser; reset loads the released (post-inversion 0) level
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= Raw ^ INV_MASK;
            sync2 <= sync1;
        end
    end

    // Per-bit filter: count while s2 differs from Stable, accept at CNT_MAX-1.
    // Any agreeing sample drops the count back to zero.
    always_comb begin
        accept = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_next[i] = '0;
            if (sync2[i] != Stable[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    accept[i] = 1'b1;
                end else begin
                    cnt_next[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
        stable_next = Stable ^ accept;
    end

    // Counters, debounced level and its OR-reduction
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt[i] <= '0;
            end
            Stable <= '0;
            Any    <= 1'b0;
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt[i] <= cnt_next[i];
            end
            Stable <= stable_next;
            Any    <= |stable_next;
        end
    end

`ifdef KEY_DEBOUNCE_CHANGE_EN
    // One-cycle pulse on the same edge Stable toggles
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Change <= '0;
        end else begin
            Change <= accept;
        end
    end
`else
    assign Change = '0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// ---------------------------------------------------------------------------
// tb_key_debounce
//   Directed and randomized stimulus for key_debounce (WIDTH=8, CNT_W=4,
//   CNT_MAX=4, ACTIVE_LOW=1). A behavioural model tracks, per bit, how many
//   consecutive synchronised samples disagree with the accepted level and
//   accepts once that run reaches CNT_MAX. Change is expected only when
//   KEY_DEBOUNCE_CHANGE_EN is defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_key_debounce;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned CNT_MAX = 4;

    logic             Clk;
    logic             Reset;
    logic [WIDTH-1:0] Raw;
    logic [WIDTH-1:0] Stable;
    logic [WIDTH-1:0] Change;
    logic             Any;

    int checks;
    int errors;

    // Reference model state
    logic [WIDTH-1:0] m_s1;
    logic [WIDTH-1:0] m_s2;
    logic [WIDTH-1:0] m_stable;
    logic [WIDTH-1:0] m_change;
    int               m_run [WIDTH];

    key_debounce #(
        .WIDTH(WIDTH), .CNT_W(CNT_W), .CNT_MAX(CNT_MAX), .ACTIVE_LOW(1)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Raw(Raw),
        .Stable(Stable), .Change(Change), .Any(Any)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [WIDTH-1:0] exp_change(input logic [WIDTH-1:0] c);
`ifdef KEY_DEBOUNCE_CHANGE_EN
        return c;
`else
        return '0;
`endif
    endfunction

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1     = '0;
        m_s2     = '0;
        m_stable = '0;
        m_change = '0;
        for (int i = 0; i < int'(WIDTH); i++) m_run[i] = 0;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".stable"}, Stable, m_stable);
        check({tag, ".change"}, Change, exp_change(m_change));
        check({tag, ".any"}, WIDTH'(Any), WIDTH'(|m_stable));
    endtask

    // One clock edge: advance the model with the values seen at the edge
    task automatic tick(input string tag);
        @(posedge Clk);
        if (Reset) begin
            model_reset();
        end else begin
            m_change = '0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (m_s2[i] != m_stable[i]) begin
                    m_run[i]++;
                    if (m_run[i] == int'(CNT_MAX)) begin
                        m_stable[i] = ~m_stable[i];
                        m_change[i] = 1'b1;
                        m_run[i]    = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = ~Raw;
        end
        #1;
        check_model(tag);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // 1. Reset with all keys released
        Raw   = 8'hFF;
        Reset = 1'b0;
        #1 Reset = 1'b1;
        model_reset();
        #1;
        check("rst.stable", Stable, 8'h00);
        check("rst.change", Change, 8'h00);
        check("rst.any", WIDTH'(Any), 8'h00);
        tick("rst_hold");
        tick("rst_hold");
        Reset = 1'b0;
        for (int k = 0; k < 20; k++) tick("idle");
        check("idle.stable", Stable, 8'h00);

        // 2. Clean press of bit 0: accepted exactly 6 edges after the step
        Raw = 8'hFE;
        for (int k = 0; k < 5; k++) begin
            tick("press0");
            check("press0.early", Stable, 8'h00);
        end
        tick("press0");
        check("press0.stable", Stable, 8'h01);
        check("press0.change", Change, exp_change(8'h01));
        check("press0.any", WIDTH'(Any), 8'h01);
        tick("press0_after");
        check("press0.pulse_end", Change, 8'h00);

        // 3. Bounce on bit 1: 3 low cycles rejected, 4 low cycles accepted
        Raw = 8'hFC;
        for (int k = 0; k < 3; k++) tick("glitch3");
        Raw = 8'hFE;
        for (int k = 0; k < 8; k++) begin
            tick("glitch3_rel");
            check("glitch3.stable", Stable, 8'h01);
        end
        Raw = 8'hFC;
        for (int k = 0; k < 4; k++) tick("glitch4");
        Raw = 8'hFE;
        tick("glitch4");
        tick("glitch4");
        check("glitch4.stable", Stable, 8'h03);
        check("glitch4.change", Change, exp_change(8'h02));
        for (int k = 0; k < 12; k++) tick("glitch4_rel");
        check("glitch4.released", Stable, 8'h01);

        // 4. Release all, then a simultaneous multi-bit step
        Raw = 8'hFF;
        for (int k = 0; k < 12; k++) tick("rel_all");
        check("rel_all.stable", Stable, 8'h00);
        Raw = 8'h5A;
        for (int k = 0; k < 5; k++) tick("multi");
        check("multi.early", Stable, 8'h00);
        tick("multi");
        check("multi.stable", Stable, 8'hA5);
        check("multi.change", Change, exp_change(8'hA5));
        Raw = 8'hFF;
        for (int k = 0; k < 12; k++) tick("multi_rel");

        // 5. Reset in the middle of a count on bit 2
        Raw = 8'hFB;
        for (int k = 0; k < 3; k++) tick("midrst");
        Reset = 1'b1;
        model_reset();
        #1;
        check("midrst.stable", Stable, 8'h00);
        check("midrst.change", Change, 8'h00);
        check("midrst.any", WIDTH'(Any), 8'h00);
        tick("midrst_hold");
        Reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick("midrst_restart");
            check("midrst.early", Stable, 8'h00);
        end
        tick("midrst_restart");
        check("midrst.accept", Stable, 8'h04);
        check("midrst.pulse", Change, exp_change(8'h04));
        Raw = 8'hFF;
        for (int k = 0; k < 12; k++) tick("midrst_rel");

        // Randomized: alternating noisy (bounce-heavy) and calm (held) phases
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (((cyc / 40) % 2) == 0) begin
                for (int i = 0; i < int'(WIDTH); i++) begin
                    if ($urandom_range(0, 3) == 0) Raw[i] = ~Raw[i];
                end
            end else if ((cyc % 12) == 0) begin
                Raw = WIDTH'($urandom);
            end
            if (cyc == 333) begin
                Reset = 1'b1;
                model_reset();
                #1;
                check("rand.rst", Stable, 8'h00);
            end
            if (cyc == 335) Reset = 1'b0;
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
